// File: rtl/xor_stream_checksum.sv
// ---------------------------------------------------------------------------
// xor_stream_checksum
//
// Streaming, frame-based XOR checksum engine. Every accepted WIDTH-bit beat
// is folded into a running XOR accumulator. When a frame ends, the result is
// parked on a valid/ready output port until the sink takes it. A frame ends
// either on a beat flagged in_last or, when no in_last shows up, on the
// MAX_BEATS-th beat. In the second case out_ovf is set.
//
// Parameters
//   WIDTH      data / checksum width in bits (>= 1)
//   MAX_BEATS  beats per frame before forced termination (>= 2)
//   CNT_W      beat-counter width, 2**CNT_W must exceed MAX_BEATS
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   in_valid      source beat valid
//   in_ready      block can accept a beat (low only while a result is held)
//   in_data       beat payload
//   in_last       final beat of the frame
//   out_valid     checksum result valid
//   out_ready     sink accepts the result
//   out_data      XOR of all beats in the frame
//   out_parity    reduction XOR of out_data
//   out_beats     number of beats folded into the result
//   out_ovf       frame was force-terminated at MAX_BEATS
//
// Optional feature (macro XOR_CHECK_EN)
//   exp_data      expected checksum, sampled only on the terminating beat
//   out_match     result equals exp_data
//   out_syndrome  result XOR exp_data
// When XOR_CHECK_EN is not defined, these three ports and the compare logic
// are absent. The rest of the block behaves the same either way.
// ---------------------------------------------------------------------------
module xor_stream_checksum #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  // source side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef XOR_CHECK_EN
  // expected-value compare
  input  logic [WIDTH-1:0] exp_data,
  output logic             out_match,
  output logic [WIDTH-1:0] out_syndrome,
`endif
  // result side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  // IDLE  : no frame open, waiting for the first beat
  // ACCUM : frame open, folding beats
  // HOLD  : result presented, waiting for the sink
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic [WIDTH-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit_max;
  logic             terminate;
  logic             force_end;

  // Handshake flags are decoded from the state register alone, so there
  // is no combinational path from out_ready to in_ready.
  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;

  // The accumulator and counter already sit at zero in IDLE. Forcing the
  // base to zero outside ACCUM still makes the start of a frame explicit,
  // so the first beat never depends on leftover register contents.
  // hit_max can only fire from ACCUM, because cnt_inc is 1 from IDLE and
  // MAX_BEATS is at least 2. If in_last arrives on the MAX_BEATS-th beat,
  // the frame ends normally and out_ovf stays clear.
  always_comb begin
    acc_base  = '0;
    cnt_base  = '0;
    if (state_q == ST_ACCUM) begin
      acc_base = acc_q;
      cnt_base = cnt_q;
    end
    fold      = acc_base ^ in_data;
    cnt_inc   = cnt_base + ONE_CNT;
    hit_max   = (cnt_inc == MAX_CNT);
    terminate = accept && (in_last || hit_max);
    force_end = accept && !in_last && hit_max;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Any accepted beat either opens or continues a frame,
  // or ends it. HOLD is left only when the sink takes the result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (terminate) begin
          state_d = ST_HOLD;
        end else if (accept) begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Running accumulator and beat counter. Both clear on the terminating
  // beat, so the next frame starts clean even straight after an overflow.
  // Reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (terminate) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      acc_q <= fold;
      cnt_q <= cnt_inc;
    end
  end

  // Result registers. They load only on the terminating beat and then stay
  // frozen through HOLD, so the sink sees a stable word for as long as it
  // stalls. Reset clears any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_parity <= 1'b0;
      out_beats  <= '0;
      out_ovf    <= 1'b0;
    end else if (terminate) begin
      out_data   <= fold;
      out_parity <= ^fold;
      out_beats  <= cnt_inc;
      out_ovf    <= force_end;
    end
  end

`ifdef XOR_CHECK_EN
  // Expected-value compare. exp_data matters only on the terminating beat.
  // Its outcome is registered next to the checksum, so it shares the same
  // hold behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_match    <= 1'b0;
      out_syndrome <= '0;
    end else if (terminate) begin
      out_match    <= (fold == exp_data);
      out_syndrome <= fold ^ exp_data;
    end
  end
`endif

endmodule

// File: tb/tb_xor_stream_checksum.sv
// ---------------------------------------------------------------------------
// tb_xor_stream_checksum
//
// Directed, table-driven bench for xor_stream_checksum. The DUT is built with
// WIDTH=8 and MAX_BEATS=4, so the overflow path is reached after only a few
// beats. Frames that run at full speed are listed in a vector table. The
// multi-cycle corner cases (sink stall, reset mid-frame, reset mid-hold and
// the optional compare feature) are written out by hand.
// ---------------------------------------------------------------------------
module tb_xor_stream_checksum;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 3;
  localparam int NV        = 7;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic [CNT_W-1:0] out_beats;
  logic             out_ovf;
`ifdef XOR_CHECK_EN
  logic [WIDTH-1:0] exp_data;
  logic             out_match;
  logic [WIDTH-1:0] out_syndrome;
`endif

  int n_cmp;
  int n_fail;

  // One table entry describes one frame. bub[i] is the number of idle
  // cycles inserted before beat i.
  typedef struct {
    string      name;
    int         n;
    logic [7:0] d [6];
    int         bub [6];
    bit         last_end;
    logic [7:0] e_data;
    bit         e_par;
    int         e_beats;
    bit         e_ovf;
  } vec_t;

  vec_t vecs [NV];

  xor_stream_checksum #(
    .WIDTH    (WIDTH),
    .MAX_BEATS(MAX_BEATS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
`ifdef XOR_CHECK_EN
    .exp_data    (exp_data),
    .out_match   (out_match),
    .out_syndrome(out_syndrome),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_parity  (out_parity),
    .out_beats   (out_beats),
    .out_ovf     (out_ovf)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net, so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // A single comparison. It counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Drives one beat at the falling edge, lets it be taken on the rising
  // edge, and then returns at the next falling edge with valid dropped.
  task automatic applyStimulus(input string name, input logic [7:0] data,
                               input logic last);
    checkOutput({name, "/in_ready_pre"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'hAA;
  endtask

  // A bubble cycle. in_data carries junk that must not be folded in.
  task automatic idleCycle();
    in_valid = 1'b0;
    in_data  = 8'hC3;
    @(posedge clk);
    @(negedge clk);
  endtask

  // The full result check, made while the DUT is expected to sit in HOLD.
  task automatic checkResult(input string name, input logic [7:0] e_data,
                             input bit e_par, input int e_beats,
                             input bit e_ovf);
    checkOutput({name, "/out_valid"},  32'(out_valid),  32'd1);
    checkOutput({name, "/in_ready"},   32'(in_ready),   32'd0);
    checkOutput({name, "/out_data"},   32'(out_data),   32'(e_data));
    checkOutput({name, "/out_parity"}, 32'(out_parity), 32'(e_par));
    checkOutput({name, "/out_beats"},  32'(out_beats),  32'(e_beats));
    checkOutput({name, "/out_ovf"},    32'(out_ovf),    32'(e_ovf));
  endtask

  // Checks that the block has returned to IDLE, one cycle after the sink
  // took the result.
  task automatic checkIdle(input string name);
    checkOutput({name, "/out_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({name, "/in_ready_back"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef XOR_CHECK_EN
    exp_data  = '0;
`endif

    // Hand-computed frames. Every result is the XOR of the listed beats.
    vecs[0] = '{name:"f3", n:3, d:'{8'h12,8'h34,8'h0F,0,0,0},
                bub:'{0,0,0,0,0,0}, last_end:1,
                e_data:8'h29, e_par:1, e_beats:3, e_ovf:0};
    vecs[1] = '{name:"ovf", n:4, d:'{8'h01,8'h02,8'h04,8'h08,0,0},
                bub:'{0,0,0,0,0,0}, last_end:0,
                e_data:8'h0F, e_par:0, e_beats:4, e_ovf:1};
    vecs[2] = '{name:"post_ovf", n:1, d:'{8'h55,0,0,0,0,0},
                bub:'{0,0,0,0,0,0}, last_end:1,
                e_data:8'h55, e_par:0, e_beats:1, e_ovf:0};
    vecs[3] = '{name:"bubbles", n:2, d:'{8'hFF,8'hFF,0,0,0,0},
                bub:'{0,2,0,0,0,0}, last_end:1,
                e_data:8'h00, e_par:0, e_beats:2, e_ovf:0};
    vecs[4] = '{name:"last_at_max", n:4, d:'{8'h11,8'h22,8'h44,8'h88,0,0},
                bub:'{0,0,0,0,0,0}, last_end:1,
                e_data:8'hFF, e_par:0, e_beats:4, e_ovf:0};
    vecs[5] = '{name:"single", n:1, d:'{8'hA5,0,0,0,0,0},
                bub:'{0,0,0,0,0,0}, last_end:1,
                e_data:8'hA5, e_par:0, e_beats:1, e_ovf:0};
    vecs[6] = '{name:"two_bub", n:2, d:'{8'h80,8'h03,0,0,0,0},
                bub:'{0,1,0,0,0,0}, last_end:1,
                e_data:8'h83, e_par:1, e_beats:2, e_ovf:0};

    // Reset, with the values checked right after it is released.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset/out_valid",  32'(out_valid),  32'd0);
    checkOutput("reset/in_ready",   32'(in_ready),   32'd1);
    checkOutput("reset/out_data",   32'(out_data),   32'd0);
    checkOutput("reset/out_parity", 32'(out_parity), 32'd0);
    checkOutput("reset/out_beats",  32'(out_beats),  32'd0);
    checkOutput("reset/out_ovf",    32'(out_ovf),    32'd0);

    // Table-driven frames, with the sink always ready.
    for (int v = 0; v < NV; v++) begin
      out_ready = 1'b1;
      for (int b = 0; b < vecs[v].n; b++) begin
        for (int k = 0; k < vecs[v].bub[b]; k++) idleCycle();
        applyStimulus(vecs[v].name, vecs[v].d[b],
                      logic'(vecs[v].last_end && (b == vecs[v].n - 1)));
      end
      checkResult(vecs[v].name, vecs[v].e_data, vecs[v].e_par,
                  vecs[v].e_beats, vecs[v].e_ovf);
      @(posedge clk);
      @(negedge clk);
      checkIdle(vecs[v].name);
    end

    // Sink stall. The result must stay put for 5 cycles. A beat offered
    // during HOLD must be refused.
    out_ready = 1'b0;
    applyStimulus("stall", 8'hA5, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("stall%0d/out_valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stall%0d/out_data", c),  32'(out_data),  32'hA5);
      checkOutput($sformatf("stall%0d/in_ready", c),  32'(in_ready),  32'd0);
      if (c < 4) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkIdle("stall");
    applyStimulus("after_stall", 8'h3C, 1'b1);
    checkResult("after_stall", 8'h3C, 1'b0, 1, 1'b0);
    @(posedge clk);
    @(negedge clk);

    // Reset after 2 beats of a 4-beat frame. The partial frame must vanish.
    applyStimulus("rst_mid", 8'h11, 1'b0);
    applyStimulus("rst_mid", 8'h22, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_mid/out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid/in_ready",  32'(in_ready),  32'd1);
    applyStimulus("rst_mid_new", 8'h3C, 1'b1);
    checkResult("rst_mid_new", 8'h3C, 1'b0, 1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkIdle("rst_mid_new");

    // Reset while a result is held. The pending result must be dropped.
    out_ready = 1'b0;
    applyStimulus("rst_hold", 8'h77, 1'b1);
    checkOutput("rst_hold/out_valid_pre", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_hold/out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_hold/out_data",  32'(out_data),  32'd0);
    checkOutput("rst_hold/in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;

`ifdef XOR_CHECK_EN
    // Compare feature: one expected value that matches, one that is off by
    // a single bit.
    applyStimulus("chk_ok", 8'h12, 1'b0);
    exp_data = 8'h26;
    applyStimulus("chk_ok", 8'h34, 1'b1);
    exp_data = 8'h00;
    checkResult("chk_ok", 8'h26, 1'b1, 2, 1'b0);
    checkOutput("chk_ok/out_match",    32'(out_match),    32'd1);
    checkOutput("chk_ok/out_syndrome", 32'(out_syndrome), 32'h00);
    @(posedge clk);
    @(negedge clk);
    applyStimulus("chk_bad", 8'h12, 1'b0);
    exp_data = 8'h27;
    applyStimulus("chk_bad", 8'h34, 1'b1);
    exp_data = 8'h00;
    checkOutput("chk_bad/out_match",    32'(out_match),    32'd0);
    checkOutput("chk_bad/out_syndrome", 32'(out_syndrome), 32'h01);
    @(posedge clk);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_stream_checksum.md
Name: xor_stream_checksum

Overview:
- Parametrised successor to the 2-input XOR cell: a streaming, frame-based XOR checksum engine for the SoC datapath.
- Folds each accepted WIDTH-bit beat into a running XOR accumulator.
- At the end of each frame it presents the checksum word, its reduction parity, the beat count and an overflow flag on a valid/ready output port.
- Sits between a bus-side stream source and a status/CSR sink.

Parameters:
- WIDTH, 8, data and checksum width in bits (≥1).
- MAX_BEATS, 256, maximum beats per frame before forced termination (≥2).
- CNT_W, 9, beat-counter width; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  beat payload.
- in_last  input  1  final beat of frame.
- out_valid  output  1  checksum result valid.
- out_ready  input  1  sink accepts result.
- out_data  output  WIDTH  XOR of all beats in frame.
- out_parity  output  1  reduction XOR of out_data.
- out_beats  output  CNT_W  number of beats folded into the result.
- out_ovf  output  1  frame force-terminated at MAX_BEATS.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset (sampled on a clk edge): state=IDLE; acc=0; cnt=0; out_valid=0; out_data=0; out_parity=0; out_beats=0; out_ovf=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-frame or mid-HOLD discards the partial accumulator and any pending result. No output is produced for the aborted frame.
- Beat acceptance: a beat is accepted when in_valid && in_ready. in_ready=1 in IDLE and ACCUM, 0 in HOLD (purely state-decoded; no combinational path from out_ready).
- States:
  - IDLE: no frame open. On accept with !in_last, go to ACCUM, acc=in_data, cnt=1. On accept with in_last, go to HOLD with a 1-beat result.
  - ACCUM: on accept, acc=acc^in_data and cnt=cnt+1.
    - With in_last: go to HOLD.
    - With !in_last and cnt+1==MAX_BEATS: go to HOLD with out_ovf=1.
    - Otherwise stay in ACCUM.
  - HOLD: out_valid=1. out_data, out_parity, out_beats and out_ovf are held stable until out_ready=1. On out_valid && out_ready, go to IDLE next cycle.
- Result registers load on the terminating accept:
  - out_data = acc ^ in_data (acc taken as 0 from IDLE).
  - out_parity = ^(acc ^ in_data).
  - out_beats = cnt+1.
  - out_ovf as above.
  - acc and cnt clear to 0 on the same edge.
- Latency: out_valid rises on the clk edge that accepts the terminating beat, i.e. it is visible the cycle after that beat is presented. Minimum frame period is 1 beat cycle + 1 HOLD cycle.
- in_valid low in ACCUM leaves acc and cnt unchanged (bubbles allowed).
- in_last together with reaching MAX_BEATS: the frame ends normally with out_ovf=0. out_ovf=1 only when the MAX_BEATS-th beat lacks in_last. After an overflow, the next beats start a new frame.
- out_ready is ignored while out_valid=0.
- Arithmetic: pure bitwise XOR, no carries. cnt never exceeds MAX_BEATS.

Optional Feature:
- Macro: XOR_CHECK_EN.
- Defined:
  - Adds input exp_data [WIDTH], sampled only on the terminating accept.
  - Adds output out_match [1], registered with the result: out_match = ((acc^in_data)==exp_data). Reset value 0; held through HOLD.
  - Adds output out_syndrome [WIDTH] = (acc^in_data)^exp_data, same timing. Reset value 0.
- Undefined: neither port exists, no compare logic is built, and all other behaviour is identical.

Test Plan:
- Reset, then frame 0x12,0x34,0x0F(last) with out_ready=1 → out_data=0x29, out_parity=1, out_beats=3, out_ovf=0; out_valid high exactly one cycle; in_ready=0 during that cycle.
- Single-beat frame 0xA5(last), out_ready held 0 for 5 cycles → out_valid and out_data=0xA5 stable 5 cycles, in_ready=0 throughout; returns to IDLE the cycle after out_ready=1.
- MAX_BEATS=4, beats 0x01,0x02,0x04,0x08 with no last → out_ovf=1, out_data=0x0F, out_beats=4; following beat 0x55(last) → new result 0x55, out_beats=1, out_ovf=0.
- Frame 0xFF,bubble,bubble,0xFF(last) → out_data=0x00, out_parity=0, out_beats=2.
- Assert reset after 2 beats of a 4-beat frame, then send 0x3C(last) → out_data=0x3C, out_beats=1; no stale result emitted.
- XOR_CHECK_EN: frame 0x12,0x34(last), exp_data=0x26 → out_match=1, out_syndrome=0x00. Same frame with exp_data=0x27 → out_match=0, out_syndrome=0x01.
